// File: rtl/imem_pkg.sv
// Shared types and width defaults for the instruction-memory arbiter.
// Optional feature macro: IMEM_RUN_WRITE_EN (loader writes allowed in RUN).
package imem_pkg;

  localparam int IMEM_ADDR_W = 16;
  localparam int IMEM_DATA_W = 32;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } phase_e;

  typedef struct packed {
    logic [IMEM_ADDR_W-1:0] addr;
    logic [IMEM_DATA_W-1:0] wdata;
  } wr_req_t;

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and BRAM signals of the instruction-memory arbiter.
// slave: arbiter view; master: requesters/BRAM view.
interface imem_arbiter_if
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_grant;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_ack;
  logic              ld_done;
  logic              running;
  logic              ld_drop;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, ld_done, mem_rdata,
    output fetch_grant, fetch_data, fetch_valid, ld_ack, running, ld_drop,
           mem_addr, mem_wdata, mem_we
  );

  modport master (
    output fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, ld_done, mem_rdata,
    input  fetch_grant, fetch_data, fetch_valid, ld_ack, running, ld_drop,
           mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/imem_lat_pipe.sv
// Valid shift register tracking BRAM read latency. Bit 0 mirrors the
// registered grant; bit STAGES is the data-valid strobe.
module imem_lat_pipe #(
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic in_vld,
  output logic out_vld
);
  logic [STAGES:0] vld_pipe;

  // shift grants toward the output, one stage per cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:0], in_vld};
  end

  assign out_vld = vld_pipe[STAGES];
endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction BRAM arbiter: loader owns the port in LOAD,
// fetch owns it in RUN. With IMEM_RUN_WRITE_EN defined, loader writes are
// also arbitrated in RUN with a starvation bound; otherwise they are
// acked, discarded and flagged on ld_drop.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W     = IMEM_ADDR_W,
  parameter int DATA_W     = IMEM_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rstn,
  imem_arbiter_if.slave bus
);
  if (MEM_LAT < 1 || MEM_LAT > 3) begin : g_bad_lat
    $error("MEM_LAT must be 1..3");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("STARVE_MAX must be >= 1");
  end

  phase_e            state, state_nx;
  logic              done_pend, done_pend_nx;
  logic              grant_q, grant_nx;
  logic              we_q, we_nx;
  logic              ack_q, ack_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [DATA_W-1:0] wdata_q, wdata_nx;
  logic              ld_free;
  logic              fetch_valid;

  // a held request is not re-accepted in its own ack cycle
  assign ld_free = bus.ld_req && !ack_q;

`ifdef IMEM_RUN_WRITE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_nx;
  logic          ld_win;

  assign ld_win = ld_free && (!bus.fetch_req || starve_q == SW'(STARVE_MAX));
`else
  logic drop_q, drop_nx;
`endif

  // phase transitions, arbitration and next-cycle BRAM port values
  always_comb begin
    state_nx     = state;
    done_pend_nx = done_pend;
    grant_nx     = 1'b0;
    we_nx        = 1'b0;
    ack_nx       = 1'b0;
    addr_nx      = addr_q;
    wdata_nx     = wdata_q;
`ifdef IMEM_RUN_WRITE_EN
    starve_nx    = starve_q;
`else
    drop_nx      = drop_q;
`endif
    case (state)
      LOAD: begin
        if (ld_free) begin
          we_nx    = 1'b1;
          ack_nx   = 1'b1;
          addr_nx  = bus.ld_addr;
          wdata_nx = bus.ld_wdata;
        end
        // hand over only once the last accepted write is on the bus
        if ((bus.ld_done || done_pend) && !ld_free) begin
          state_nx     = RUN;
          done_pend_nx = 1'b0;
        end else if (bus.ld_done) begin
          done_pend_nx = 1'b1;
        end
      end
      RUN: begin
`ifdef IMEM_RUN_WRITE_EN
        if (ld_win) begin
          we_nx    = 1'b1;
          ack_nx   = 1'b1;
          addr_nx  = bus.ld_addr;
          wdata_nx = bus.ld_wdata;
        end else if (bus.fetch_req) begin
          grant_nx = 1'b1;
          addr_nx  = bus.fetch_addr;
        end
        if (ld_win || !bus.ld_req)
          starve_nx = '0;
        else if (bus.fetch_req && starve_q != SW'(STARVE_MAX))
          starve_nx = starve_q + 1'b1;
`else
        if (bus.fetch_req) begin
          grant_nx = 1'b1;
          addr_nx  = bus.fetch_addr;
        end
        if (ld_free) begin
          ack_nx  = 1'b1;
          drop_nx = 1'b1;
        end
`endif
      end
      default: state_nx = LOAD;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= LOAD;
      done_pend <= 1'b0;
      grant_q   <= 1'b0;
      we_q      <= 1'b0;
      ack_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state     <= state_nx;
      done_pend <= done_pend_nx;
      grant_q   <= grant_nx;
      we_q      <= we_nx;
      ack_q     <= ack_nx;
      addr_q    <= addr_nx;
      wdata_q   <= wdata_nx;
    end
  end

`ifdef IMEM_RUN_WRITE_EN
  // consecutive fetch grants while a loader write waits
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) starve_q <= '0;
    else       starve_q <= starve_nx;
  end
  assign bus.ld_drop = 1'b0;
`else
  // sticky flag for loader writes discarded in RUN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) drop_q <= 1'b0;
    else       drop_q <= drop_nx;
  end
  assign bus.ld_drop = drop_q;
`endif

  imem_lat_pipe #(.STAGES(MEM_LAT)) u_lat_pipe (
    .clk     (clk),
    .rstn    (rstn),
    .in_vld  (grant_nx),
    .out_vld (fetch_valid)
  );

  assign bus.fetch_grant = grant_q;
  assign bus.fetch_valid = fetch_valid;
  assign bus.fetch_data  = bus.mem_rdata;
  assign bus.ld_ack      = ack_q;
  assign bus.running     = (state == RUN);
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_we      = we_q;
endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: stimulus pushes expected BRAM writes
// and fetch read data; a negedge monitor pops and compares them.
// Feature-dependent expectations follow IMEM_RUN_WRITE_EN.
module tb_imem_arbiter;
  import imem_pkg::*;

  localparam int MEM_LAT = 1;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   failures = 0;
  int   n_grant = 0;

  imem_arbiter_if bif ();

  imem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  // BRAM model: write-enable plus MEM_LAT-cycle registered read
  logic [31:0] mem [256];
  logic [31:0] rdq [MEM_LAT];
  always @(posedge clk) begin
    if (bif.mem_we) mem[bif.mem_addr[7:0]] <= bif.mem_wdata;
    rdq[0] <= mem[bif.mem_addr[7:0]];
    for (int i = 1; i < MEM_LAT; i++) rdq[i] <= rdq[i-1];
  end
  assign bif.mem_rdata = rdq[MEM_LAT-1];

  wr_req_t     wq[$];
  logic [31:0] rq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor: compare every BRAM write and every valid fetch word
  wr_req_t     we_e;
  logic [31:0] re_e;
  always @(negedge clk) begin
    if (rstn) begin
      if (bif.fetch_grant) n_grant++;
      if (bif.mem_we) begin
        if (wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_unexpected actual=%0h:%0h expected=none", bif.mem_addr, bif.mem_wdata);
        end else begin
          we_e = wq.pop_front();
          chk("wr_addr", bif.mem_addr, we_e.addr);
          chk("wr_data", bif.mem_wdata, we_e.wdata);
        end
      end
      if (bif.fetch_valid) begin
        if (rq.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_unexpected actual=%0h expected=none", bif.fetch_data);
        end else begin
          re_e = rq.pop_front();
          chk("rd_data", bif.fetch_data, re_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_running"}, bif.running, 0);
    chk({tag, "_grant"}, bif.fetch_grant, 0);
    chk({tag, "_valid"}, bif.fetch_valid, 0);
    chk({tag, "_ack"}, bif.ld_ack, 0);
    chk({tag, "_we"}, bif.mem_we, 0);
    chk({tag, "_addr"}, bif.mem_addr, 0);
    chk({tag, "_wdata"}, bif.mem_wdata, 0);
    chk({tag, "_drop"}, bif.ld_drop, 0);
  endtask

  // LOAD write; optionally pulse ld_done in the ack cycle
  task automatic ld_wr(input logic [15:0] a, input logic [31:0] d, input bit done);
    wr_req_t t;
    t.addr = a; t.wdata = d;
    bif.ld_req = 1'b1; bif.ld_addr = a; bif.ld_wdata = d;
    wq.push_back(t);
    tick();
    chk("ld_ack", bif.ld_ack, 1);
    chk("ld_running", bif.running, 0);
    bif.ld_req = 1'b0;
    if (done) begin
      bif.ld_done = 1'b1;
      bif.fetch_req = 1'b0;
    end
    tick();
    bif.ld_done = 1'b0;
    chk("ld_ack_pulse", bif.ld_ack, 0);
    if (done) chk("run_after_done", bif.running, 1);
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] d);
    bif.fetch_req = 1'b1; bif.fetch_addr = a;
    rq.push_back(d);
    tick();
    chk("rd_grant", bif.fetch_grant, 1);
    chk("rd_addr", bif.mem_addr, a);
    bif.fetch_req = 1'b0;
    repeat (MEM_LAT) tick();
    chk("rd_valid", bif.fetch_valid, 1);
    tick();
  endtask

  // fetch held high with a competing loader write to address 3
  task automatic run_burst();
    bit      lw;
    wr_req_t t;
    t.addr = 16'h0003; t.wdata = 32'h3333_3333;
    bif.fetch_req = 1'b1; bif.fetch_addr = 16'h0000;
    bif.ld_req = 1'b1; bif.ld_addr = t.addr; bif.ld_wdata = t.wdata;
    for (int c = 0; c < 11; c++) begin
      if (c == 9) bif.ld_req = 1'b0;
`ifdef IMEM_RUN_WRITE_EN
      lw = (c == 8);
`else
      lw = 1'b0;
`endif
      if (lw) wq.push_back(t);
      else    rq.push_back(32'hDEAD_BEEF);
      tick();
      chk("burst_grant", bif.fetch_grant, !lw);
      chk("burst_we", bif.mem_we, lw);
`ifdef IMEM_RUN_WRITE_EN
      chk("burst_ack", bif.ld_ack, lw);
`else
      chk("burst_ack", bif.ld_ack, (c % 2 == 0) && (c < 9));
`endif
    end
    bif.fetch_req = 1'b0;
    repeat (MEM_LAT + 1) tick();
  endtask

  int g0;

  initial begin
    rstn = 1'b0;
    bif.fetch_req = 1'b0; bif.fetch_addr = '0;
    bif.ld_req = 1'b0; bif.ld_addr = '0; bif.ld_wdata = '0; bif.ld_done = 1'b0;
    repeat (2) tick();
    chk_reset_outs("rst");
    rstn = 1'b1;
    tick();

    // LOAD: fetch requests must be ignored
    bif.fetch_req = 1'b1; bif.fetch_addr = 16'h0001;
    ld_wr(16'h0000, 32'hDEAD_BEEF, 1'b0);
    ld_wr(16'h0001, 32'h1234_5678, 1'b0);
    ld_wr(16'h0002, 32'hCAFE_0002, 1'b1);
    chk("load_no_grant", n_grant, 0);
    rd(16'h0001, 32'h1234_5678);

    // RUN loader write with fetch idle
    bif.ld_req = 1'b1; bif.ld_addr = 16'h0002; bif.ld_wdata = 32'hBAD0_0002;
`ifdef IMEM_RUN_WRITE_EN
    begin
      wr_req_t t;
      t.addr = 16'h0002; t.wdata = 32'hBAD0_0002;
      wq.push_back(t);
    end
`endif
    tick();
    chk("idle_ack", bif.ld_ack, 1);
    chk("idle_grant", bif.fetch_grant, 0);
`ifdef IMEM_RUN_WRITE_EN
    chk("idle_we", bif.mem_we, 1);
    chk("idle_drop", bif.ld_drop, 0);
`else
    chk("idle_we", bif.mem_we, 0);
    chk("idle_drop", bif.ld_drop, 1);
`endif
    bif.ld_req = 1'b0;
    tick();
`ifdef IMEM_RUN_WRITE_EN
    chk("drop_sticky", bif.ld_drop, 0);
    rd(16'h0002, 32'hBAD0_0002);
`else
    chk("drop_sticky", bif.ld_drop, 1);
    rd(16'h0002, 32'hCAFE_0002);
`endif

    run_burst();
    run_burst();

    // ld_done in RUN has no effect
    bif.ld_done = 1'b1;
    tick();
    bif.ld_done = 1'b0;
    tick();
    chk("run_done_ignored", bif.running, 1);

    // reset in the middle of a fetch grant
    bif.fetch_req = 1'b1; bif.fetch_addr = 16'h0000;
    tick();
    chk("pre_rst_grant", bif.fetch_grant, 1);
    rstn = 1'b0;
    #1;
    chk_reset_outs("midrst");
    tick();
    rstn = 1'b1;
    g0 = n_grant;
    repeat (3) begin
      tick();
      chk("post_rst_grant", bif.fetch_grant, 0);
      chk("post_rst_running", bif.running, 0);
    end
    bif.fetch_req = 1'b0;
    ld_wr(16'h0005, 32'h5555_5555, 1'b0);
    chk("post_rst_no_grant", n_grant - g0, 0);

    tick();
    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Owns the single port of the instruction BRAM and shares it between two requesters: the fetch stage (reads) and the UART program loader (writes).
- After reset the loader owns the memory (LOAD phase). On the loader's done pulse the block hands the port to fetch (RUN phase).
- Sits between the fetch stage's inst_addr/inst_data pair and the BRAM.
- Tracks BRAM read latency so that fetch gets a qualified data-valid strobe.

Parameters:
- ADDR_W, 16, instruction word address width (matches the fetch stage's 16-bit inst_addr).
- DATA_W, 32, instruction word width.
- MEM_LAT, 1, BRAM read latency in cycles (1..3).
- STARVE_MAX, 8, maximum consecutive fetch grants in RUN while a loader write waits.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- fetch_req  in  1  fetch requests a read this cycle.
- fetch_addr  in  ADDR_W  read word address.
- fetch_grant  out  1  read issued to BRAM this cycle.
- fetch_data  out  DATA_W  read data, qualified by fetch_valid.
- fetch_valid  out  1  fetch_data holds the word for the grant made MEM_LAT cycles earlier.
- ld_req  in  1  loader write request; held with ld_addr/ld_wdata until ld_ack.
- ld_addr  in  ADDR_W  write word address.
- ld_wdata  in  DATA_W  write data.
- ld_ack  out  1  one-cycle pulse: write accepted.
- ld_done  in  1  one-cycle pulse: program image complete.
- running  out  1  high in RUN phase.
- ld_drop  out  1  sticky: a loader write was discarded in RUN (only without the optional feature).
- mem_addr  out  ADDR_W  BRAM address.
- mem_wdata  out  DATA_W  BRAM write data.
- mem_we  out  1  BRAM write enable.
- mem_rdata  in  DATA_W  BRAM read data.

Behaviour:
- All outputs are registered except fetch_data, which is a passthrough of mem_rdata.
- Reset values: state=LOAD, running=0, fetch_grant=0, fetch_valid=0, ld_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, ld_drop=0, starve counter=0, valid pipe=0.
- LOAD phase:
  - fetch_grant is never asserted.
  - ld_req at cycle t gives: mem_we=1 with ld_addr/ld_wdata in cycle t+1, and ld_ack=1 in cycle t+1.
  - The loader must drop or advance ld_req in cycle t+1. If ld_req is still high in t+1 it is treated as a new write (back-to-back throughput is 1 write per 2 cycles).
  - ld_done moves the state to RUN on the next edge, but only once no write is in flight (ld_ack of the last write already issued). If ld_done coincides with an in-flight write, the transition happens the cycle after that write.
- RUN phase:
  - running=1.
  - Arbitration is evaluated each cycle:
    - Fetch wins by default.
    - Loader wins if fetch_req=0, or if the starve counter has reached STARVE_MAX with ld_req high.
  - On a fetch grant at cycle t: mem_addr=fetch_addr and fetch_grant=1 in cycle t+1; fetch_valid=1 in cycle t+1+MEM_LAT.
  - Starve counter:
    - Increments on each fetch grant while ld_req=1 and saturates at STARVE_MAX.
    - Clears on a loader grant or when ld_req=0.
  - A loader grant takes one slot. fetch_grant=0 in that slot, and fetch must hold fetch_addr/fetch_req.
- ld_done in RUN is ignored. Only reset returns the block to LOAD.
- Reset mid-write: mem_we drops immediately (asynchronous). The in-progress write is not guaranteed.
- MEM_LAT valid pipe: a shift register of grants. Entries already in the pipe are not cancelled by a loader slot.

Optional Feature:
- Macro: IMEM_RUN_WRITE_EN.
- Defined: loader writes are arbitrated in RUN as described above (self-modifying or debug patching). ld_drop is tied to 0.
- Undefined:
  - In RUN, ld_req is acked one cycle later with mem_we kept at 0, and ld_drop is set sticky until reset.
  - Fetch is never preempted and the starve counter logic is removed.

Decomposition:
- Package imem_pkg holds:
  - ADDR_W/DATA_W defaults;
  - the phase enum (LOAD, RUN);
  - a write-request struct {addr, wdata}.
- One sub-module: imem_lat_pipe (MEM_LAT-deep valid shift register, reset to 0).
- The arbiter FSM and starve counter stay in the top module.

Test Plan:
- Reset, then ld_req with addr=0x0000/0x0001, data=0xDEADBEEF/0x12345678 → mem_we pulses with those values, ld_ack once each, fetch_grant stays 0.
- ld_done coinciding with a write ack → running rises one cycle after that write. A fetch_addr=0x0001 read then returns fetch_data=0x12345678 with fetch_valid MEM_LAT cycles after fetch_grant.
- RUN, fetch_req held high continuously, ld_req high (feature on) → exactly STARVE_MAX=8 fetch grants, then one loader write slot with fetch_grant=0, then fetch resumes.
- RUN, fetch_req low, ld_req high → write granted immediately and the starve counter does not increment.
- Feature off: RUN ld_req addr=0x0002 → ld_ack pulse, no mem_we, ld_drop=1 sticky. A later read of 0x0002 returns the old value.
- rstn asserted mid-RUN → all outputs return to reset values that cycle; ld_drop clears; the block is back in LOAD.
